// File: rtl/sram_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_scan_ctrl_if
// Description : Port-0/port-1 bus between the scan controller and the SRAM
//               macro array (chip selects, strobes, read data).
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_scan_ctrl_if #(
    parameter int NUM_SRAMS   = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4
);
    logic [NUM_SRAMS-1:0]            csb0;
    logic                            web0;
    logic [ADDR_WIDTH-1:0]           addr0;
    logic [DATA_WIDTH-1:0]           din0;
    logic [WMASK_WIDTH-1:0]          wmask0;
    logic [NUM_SRAMS-1:0]            csb1;
    logic                            web1;
    logic [ADDR_WIDTH-1:0]           addr1;
    logic [DATA_WIDTH-1:0]           din1;
    logic [WMASK_WIDTH-1:0]          wmask1;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] dout0;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] dout1;

    modport master (
        output csb0, web0, addr0, din0, wmask0,
        output csb1, web1, addr1, din1, wmask1,
        input  dout0, dout1
    );

    modport slave (
        input  csb0, web0, addr0, din0, wmask0,
        input  csb1, web1, addr1, din1, wmask1,
        output dout0, dout1
    );
endinterface
`default_nettype wire

// File: rtl/sram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_scan_ctrl
// Description : Scan-chain SRAM test responder: shifts a 112-bit command
//               frame, runs one access per strobe, loads read data back.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_scan_ctrl #(
    parameter int                   NUM_SRAMS      = 16,
    parameter logic [NUM_SRAMS-1:0] DUAL_PORT_MASK = 16'h00FF,
    parameter int                   ADDR_WIDTH     = 16,
    parameter int                   DATA_WIDTH     = 32,
    parameter int                   WMASK_WIDTH    = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           scan_en,
    input  wire logic           scan_in,
    output logic                scan_out,
    input  wire logic           sram_load,
    input  wire logic           global_csb,
    output logic                busy,
    sram_scan_ctrl_if.master    sram
);

    localparam int SEL_W      = 4;
    localparam int PORT_W     = ADDR_WIDTH + DATA_WIDTH + 2 + WMASK_WIDTH;
    localparam int FRAME_W    = SEL_W + 2 * PORT_W;

    // Field offsets, counted from the LSB end of the frame
    localparam int WMASK1_LSB = 0;
    localparam int WEB1_BIT   = WMASK_WIDTH;
    localparam int CSB1_BIT   = WMASK_WIDTH + 1;
    localparam int DIN1_LSB   = WMASK_WIDTH + 2;
    localparam int ADDR1_LSB  = DIN1_LSB + DATA_WIDTH;
    localparam int WMASK0_LSB = PORT_W;
    localparam int WEB0_BIT   = PORT_W + WMASK_WIDTH;
    localparam int CSB0_BIT   = PORT_W + WMASK_WIDTH + 1;
    localparam int DIN0_LSB   = PORT_W + WMASK_WIDTH + 2;
    localparam int ADDR0_LSB  = DIN0_LSB + DATA_WIDTH;
    localparam int SEL_LSB    = 2 * PORT_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [FRAME_W-1:0]     frame_q,     frame_d;
    logic                   arm_q,       arm_d;
    logic                   busy_q,      busy_d;
    logic [DATA_WIDTH-1:0]  cap0_q,      cap0_d;
    logic [DATA_WIDTH-1:0]  cap1_q,      cap1_d;
    logic [NUM_SRAMS-1:0]   csb0_q,      csb0_d;
    logic [NUM_SRAMS-1:0]   csb1_q,      csb1_d;
    logic                   web0_q,      web0_d;
    logic                   web1_q,      web1_d;
    logic [ADDR_WIDTH-1:0]  addr0_q,     addr0_d;
    logic [ADDR_WIDTH-1:0]  addr1_q,     addr1_d;
    logic [DATA_WIDTH-1:0]  din0_q,      din0_d;
    logic [DATA_WIDTH-1:0]  din1_q,      din1_d;
    logic [WMASK_WIDTH-1:0] wmask0_q,    wmask0_d;
    logic [WMASK_WIDTH-1:0] wmask1_q,    wmask1_d;

    logic [SEL_W-1:0]       f_sel;
    logic [ADDR_WIDTH-1:0]  f_addr0,  f_addr1;
    logic [DATA_WIDTH-1:0]  f_din0,   f_din1;
    logic                   f_csb0,   f_csb1;
    logic                   f_web0,   f_web1;
    logic [WMASK_WIDTH-1:0] f_wmask0, f_wmask1;

    assign f_sel    = frame_q[SEL_LSB    +: SEL_W];
    assign f_addr0  = frame_q[ADDR0_LSB  +: ADDR_WIDTH];
    assign f_din0   = frame_q[DIN0_LSB   +: DATA_WIDTH];
    assign f_csb0   = frame_q[CSB0_BIT];
    assign f_web0   = frame_q[WEB0_BIT];
    assign f_wmask0 = frame_q[WMASK0_LSB +: WMASK_WIDTH];
    assign f_addr1  = frame_q[ADDR1_LSB  +: ADDR_WIDTH];
    assign f_din1   = frame_q[DIN1_LSB   +: DATA_WIDTH];
    assign f_csb1   = frame_q[CSB1_BIT];
    assign f_web1   = frame_q[WEB1_BIT];
    assign f_wmask1 = frame_q[WMASK1_LSB +: WMASK_WIDTH];

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        arm_d    = arm_q;
        busy_d   = busy_q;
        cap0_d   = cap0_q;
        cap1_d   = cap1_q;
        csb0_d   = csb0_q;
        csb1_d   = csb1_q;
        web0_d   = web0_q;
        web1_d   = web1_q;
        addr0_d  = addr0_q;
        addr1_d  = addr1_q;
        din0_d   = din0_q;
        din1_d   = din1_q;
        wmask0_d = wmask0_q;
        wmask1_d = wmask1_q;

        case (state_q)
            S_IDLE: begin
                // Re-arming on a high sample is what limits a held-low strobe to one access
                if (global_csb) begin
                    arm_d = 1'b1;
                end
                if (scan_en) begin
                    frame_d = {frame_q[FRAME_W-2:0], scan_in};
                end else if (sram_load) begin
                    if (!f_csb0 && f_web0) begin
                        frame_d[DIN0_LSB +: DATA_WIDTH] = cap0_q;
                    end
                    if (!f_csb1 && f_web1) begin
                        frame_d[DIN1_LSB +: DATA_WIDTH] = cap1_q;
                    end
                end else if (!global_csb && arm_q) begin
                    state_d  = S_ACCESS;
                    arm_d    = 1'b0;
                    busy_d   = 1'b1;
                    web0_d   = f_web0;
                    addr0_d  = f_addr0;
                    din0_d   = f_din0;
                    wmask0_d = f_wmask0;
                    web1_d   = f_web1;
                    addr1_d  = f_addr1;
                    din1_d   = f_din1;
                    wmask1_d = f_wmask1;
                    csb0_d   = '1;
                    csb1_d   = '1;
                    for (int i = 0; i < NUM_SRAMS; i++) begin
                        if (f_sel == SEL_W'(i)) begin
                            csb0_d[i] = f_csb0;
                            if (DUAL_PORT_MASK[i]) begin
                                csb1_d[i] = f_csb1;
                            end
                        end
                    end
                end
            end

            S_ACCESS: begin
                state_d = S_CAPTURE;
                busy_d  = 1'b1;
                csb0_d  = '1;
                csb1_d  = '1;
            end

            S_CAPTURE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                csb0_d  = '1;
                csb1_d  = '1;
                // Out-of-range selects and absent second ports read back as zero
                cap0_d  = '0;
                cap1_d  = '0;
                for (int i = 0; i < NUM_SRAMS; i++) begin
                    if (f_sel == SEL_W'(i)) begin
                        cap0_d = sram.dout0[i*DATA_WIDTH +: DATA_WIDTH];
                        if (DUAL_PORT_MASK[i]) begin
                            cap1_d = sram.dout1[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                csb0_d  = '1;
                csb1_d  = '1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            arm_q    <= 1'b1;
            busy_q   <= 1'b0;
            cap0_q   <= '0;
            cap1_q   <= '0;
            csb0_q   <= '1;
            csb1_q   <= '1;
            web0_q   <= 1'b1;
            web1_q   <= 1'b1;
            addr0_q  <= '0;
            addr1_q  <= '0;
            din0_q   <= '0;
            din1_q   <= '0;
            wmask0_q <= '0;
            wmask1_q <= '0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            arm_q    <= arm_d;
            busy_q   <= busy_d;
            cap0_q   <= cap0_d;
            cap1_q   <= cap1_d;
            csb0_q   <= csb0_d;
            csb1_q   <= csb1_d;
            web0_q   <= web0_d;
            web1_q   <= web1_d;
            addr0_q  <= addr0_d;
            addr1_q  <= addr1_d;
            din0_q   <= din0_d;
            din1_q   <= din1_d;
            wmask0_q <= wmask0_d;
            wmask1_q <= wmask1_d;
        end
    end

    // MSB is visible before the first shift edge
    assign scan_out    = frame_q[FRAME_W-1];
    assign busy        = busy_q;
    assign sram.csb0   = csb0_q;
    assign sram.web0   = web0_q;
    assign sram.addr0  = addr0_q;
    assign sram.din0   = din0_q;
    assign sram.wmask0 = wmask0_q;
    assign sram.csb1   = csb1_q;
    assign sram.web1   = web1_q;
    assign sram.addr1  = addr1_q;
    assign sram.din1   = din1_q;
    assign sram.wmask1 = wmask1_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_scan_ctrl
// Description : Self-checking bench for sram_scan_ctrl with a macro-array
//               model and a transaction-level reference of the frame/memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_scan_ctrl;

    localparam int          NS  = 16;
    localparam int          AW  = 16;
    localparam int          DW  = 32;
    localparam int          MW  = 4;
    localparam logic [15:0] DPM = 16'h00FF;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] addr0;
        logic [31:0] din0;
        logic        csb0;
        logic        web0;
        logic [3:0]  wmask0;
        logic [15:0] addr1;
        logic [31:0] din1;
        logic        csb1;
        logic        web1;
        logic [3:0]  wmask1;
    } frame_t;

    typedef struct {
        frame_t      f;
        bit          load;
        logic [15:0] e_csb0;
        logic [15:0] e_csb1;
        logic [31:0] e_din0;
        logic [31:0] e_din1;
    } vec_t;

    logic clk = 1'b0;
    logic reset, scan_en, scan_in, sram_load, global_csb;
    logic scan_out, busy;

    sram_scan_ctrl_if #(.NUM_SRAMS(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) sif ();

    sram_scan_ctrl #(
        .NUM_SRAMS(NS), .DUAL_PORT_MASK(DPM), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .WMASK_WIDTH(MW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .scan_out   (scan_out),
        .sram_load  (sram_load),
        .global_csb (global_csb),
        .busy       (busy),
        .sram       (sif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int low_cycles = 0;

    always @(negedge clk) begin
        if (!reset && (sif.csb0 != '1 || sif.csb1 != '1)) low_cycles++;
    end

    // Macro array: reads return pre-access contents, single-port macros babble on port 1
    logic [31:0]       mem [NS][16];
    logic [NS*DW-1:0]  d0, d1;
    assign sif.dout0 = d0;
    assign sif.dout1 = d1;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NS; i++)
                for (int a = 0; a < 16; a++) mem[i][a] <= '0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (!sif.csb0[i] && sif.web0) d0[i*DW +: DW] <= mem[i][sif.addr0[3:0]];
                if (DPM[i]) begin
                    if (!sif.csb1[i] && sif.web1) d1[i*DW +: DW] <= mem[i][sif.addr1[3:0]];
                end else begin
                    d1[i*DW +: DW] <= $urandom;
                end
                for (int b = 0; b < 4; b++) begin
                    if (!sif.csb0[i] && !sif.web0 && sif.wmask0[b])
                        mem[i][sif.addr0[3:0]][b*8 +: 8] <= sif.din0[b*8 +: 8];
                    if (DPM[i] && !sif.csb1[i] && !sif.web1 && sif.wmask1[b])
                        mem[i][sif.addr1[3:0]][b*8 +: 8] <= sif.din1[b*8 +: 8];
                end
            end
        end
    end

    // Reference: frame contents, memory image and last-read words
    frame_t      ref_frame;
    logic [31:0] ref_mem [NS][16];
    logic [31:0] ref_cap0, ref_cap1;

    task automatic ref_clear();
        ref_frame = '0;
        ref_cap0  = '0;
        ref_cap1  = '0;
        for (int i = 0; i < NS; i++)
            for (int a = 0; a < 16; a++) ref_mem[i][a] = '0;
    endtask

    task automatic ref_access(output logic [15:0] e0, output logic [15:0] e1);
        frame_t f;
        logic [31:0] w;
        f  = ref_frame;
        e0 = 16'hFFFF;
        e1 = 16'hFFFF;
        e0[f.sel] = f.csb0;
        if (DPM[f.sel]) e1[f.sel] = f.csb1;
        ref_cap0 = ref_mem[f.sel][f.addr0[3:0]];
        ref_cap1 = DPM[f.sel] ? ref_mem[f.sel][f.addr1[3:0]] : 32'h0;
        if (!f.csb0 && !f.web0) begin
            w = ref_mem[f.sel][f.addr0[3:0]];
            for (int b = 0; b < 4; b++) if (f.wmask0[b]) w[b*8 +: 8] = f.din0[b*8 +: 8];
            ref_mem[f.sel][f.addr0[3:0]] = w;
        end
        if (DPM[f.sel] && !f.csb1 && !f.web1) begin
            w = ref_mem[f.sel][f.addr1[3:0]];
            for (int b = 0; b < 4; b++) if (f.wmask1[b]) w[b*8 +: 8] = f.din1[b*8 +: 8];
            ref_mem[f.sel][f.addr1[3:0]] = w;
        end
    endtask

    task automatic ref_load();
        if (!ref_frame.csb0 && ref_frame.web0) ref_frame.din0 = ref_cap0;
        if (!ref_frame.csb1 && ref_frame.web1) ref_frame.din1 = ref_cap1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic shift(input logic [111:0] fin, output logic [111:0] fout);
        scan_en = 1'b1;
        for (int i = 111; i >= 0; i--) begin
            fout[i] = scan_out;
            scan_in = fin[i];
            tick();
        end
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic load_pulse();
        sram_load = 1'b1;
        tick();
        sram_load = 1'b0;
        ref_load();
    endtask

    task automatic do_access(input string tag, output logic [15:0] g0, output logic [15:0] g1);
        logic [15:0] e0, e1;
        frame_t f;
        f = ref_frame;
        ref_access(e0, e1);
        global_csb = 1'b0;
        tick();
        global_csb = 1'b1;
        g0 = sif.csb0;
        g1 = sif.csb1;
        check({tag, "_csb0"}, sif.csb0, e0);
        check({tag, "_csb1"}, sif.csb1, e1);
        check({tag, "_shared"}, {sif.web0, sif.addr0, sif.din0, sif.web1, sif.addr1},
              {f.web0, f.addr0, f.din0, f.web1, f.addr1});
        check({tag, "_busy1"}, busy, 1'b1);
        tick();
        check({tag, "_release"}, {busy, sif.csb0, sif.csb1}, {1'b1, 32'hFFFF_FFFF});
        tick();
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    function automatic frame_t mkf(input logic [3:0] sel, input logic [15:0] a0, input logic [31:0] d0v,
                                   input logic c0, input logic w0, input logic [3:0] m0,
                                   input logic [15:0] a1, input logic [31:0] d1v,
                                   input logic c1, input logic w1, input logic [3:0] m1);
        frame_t f;
        f = '{sel, a0, d0v, c0, w0, m0, a1, d1v, c1, w1, m1};
        return f;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vt [8];
        logic [111:0] out;
        logic [127:0] rnd;
        logic [15:0]  g0, g1;
        frame_t       f, ef;
        int           base;

        vt[0] = '{mkf(3, 1, 32'h3,        0, 0, 4'hF, 0, 32'h0,        1, 1, 0), 0, 16'hFFF7, 16'hFFFF, 32'h3,        32'h0};
        vt[1] = '{mkf(3, 1, 32'h11111111, 0, 1, 0,    0, 32'h0,        1, 1, 0), 1, 16'hFFF7, 16'hFFFF, 32'h3,        32'h0};
        vt[2] = '{mkf(5, 1, 32'h5,        0, 0, 4'hF, 0, 32'h0,        1, 1, 0), 0, 16'hFFDF, 16'hFFFF, 32'h5,        32'h0};
        vt[3] = '{mkf(5, 0, 32'h0,        1, 1, 0,    2, 32'h28,       0, 0, 4'hF), 0, 16'hFFFF, 16'hFFDF, 32'h0,     32'h28};
        vt[4] = '{mkf(5, 1, 32'hCAFE0000, 0, 1, 0,    2, 32'hBEEF,     0, 1, 0), 1, 16'hFFDF, 16'hFFDF, 32'h5,        32'h28};
        vt[5] = '{mkf(9, 1, 32'h12345678, 1, 1, 0,    3, 32'hDEADBEEF, 0, 1, 0), 1, 16'hFFFF, 16'hFFFF, 32'h12345678, 32'h0};
        vt[6] = '{mkf(3, 1, 32'hAABBCCDD, 0, 0, 4'b0010, 0, 32'h0,     1, 1, 0), 0, 16'hFFF7, 16'hFFFF, 32'hAABBCCDD, 32'h0};
        vt[7] = '{mkf(3, 1, 32'h0,        0, 1, 0,    0, 32'h77,       1, 1, 0), 1, 16'hFFF7, 16'hFFFF, 32'h0000CC03, 32'h77};

        reset = 1'b1; scan_en = 1'b0; scan_in = 1'b0; sram_load = 1'b0; global_csb = 1'b1;
        ref_clear();
        tick(); tick(); tick();
        check("reset_outputs", {scan_out, busy, sif.csb0, sif.csb1, sif.web0, sif.web1},
              {2'b00, 32'hFFFF_FFFF, 2'b11});
        check("reset_buses", {sif.addr0, sif.din0, sif.wmask0, sif.addr1, sif.din1, sif.wmask1}, '0);
        reset = 1'b0;
        tick();

        // Shift-through: a frame pushed in comes back bit-exact, no access on the way
        base = low_cycles;
        rnd = {$urandom, $urandom, $urandom, $urandom};
        f = rnd[111:0];
        shift(f, out);
        check("shift_first_out", out, 112'h0);
        shift('0, out);
        check("shift_through", out, f);
        check("shift_no_csb", low_cycles - base, 0);

        // Directed table: access, optional load, read the frame back
        for (int i = 0; i < 8; i++) begin
            shift(vt[i].f, out);
            ref_frame = vt[i].f;
            do_access($sformatf("vec%0d", i), g0, g1);
            check($sformatf("vec%0d_tbl_csb", i), {g0, g1}, {vt[i].e_csb0, vt[i].e_csb1});
            if (vt[i].load) load_pulse();
            ef = vt[i].f;
            ef.din0 = vt[i].e_din0;
            ef.din1 = vt[i].e_din1;
            shift('0, out);
            check($sformatf("vec%0d_frame", i), out, ef);
            ref_frame = '0;
        end

        // Held-low strobe yields one access; release and re-strobe yields another
        f = mkf(3, 1, 32'h0, 0, 1, 0, 0, 32'h0, 1, 1, 0);
        shift(f, out);
        ref_frame = f;
        ref_access(g0, g1);
        base = low_cycles;
        global_csb = 1'b0;
        repeat (10) tick();
        global_csb = 1'b1;
        tick();
        check("hold_one_access", low_cycles - base, 1);
        check("hold_idle", busy, 1'b0);
        do_access("restrobe", g0, g1);
        check("restrobe_count", low_cycles - base, 2);
        shift('0, out);
        ref_frame = '0;

        // Randomised transactions against the reference
        for (int n = 0; n < 40; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            f = rnd[111:0];
            f.addr0 = 16'($urandom_range(0, 3));
            f.addr1 = 16'($urandom_range(0, 3));
            shift(f, out);
            check($sformatf("rand%0d_out", n), out, ref_frame);
            ref_frame = f;
            if ($urandom_range(0, 3) != 0) begin
                repeat ($urandom_range(0, 2)) tick();
                do_access($sformatf("rand%0d", n), g0, g1);
                if ($urandom_range(0, 1) == 1) load_pulse();
            end
        end
        shift('0, out);
        check("rand_final_out", out, ref_frame);
        ref_frame = '0;

        // Reset during the ACCESS cycle aborts everything asynchronously
        f = mkf(9, 2, 32'h55AA55AA, 0, 0, 4'hF, 0, 32'h0, 1, 1, 0);
        shift(f, out);
        check("rst_pre_msb", scan_out, 1'b1);
        global_csb = 1'b0;
        tick();
        global_csb = 1'b1;
        check("rst_in_access", sif.csb0, 16'hFDFF);
        #2 reset = 1'b1;
        #1;
        check("rst_async", {sif.csb0, sif.csb1, busy, scan_out, sif.web0},
              {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1});
        tick(); tick();
        reset = 1'b0;
        ref_clear();
        tick();
        base = low_cycles;
        rnd = {$urandom, $urandom, $urandom, $urandom};
        f = rnd[111:0];
        shift(f, out);
        check("rst_frame_cleared", out, 112'h0);
        shift('0, out);
        check("rst_shift_through", out, f);
        check("rst_no_csb", low_cycles - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_scan_ctrl.md
Name: sram_scan_ctrl

Overview:
- On-chip responder for the GPIO scan-chain SRAM test interface of the test chip.
- Shifts in a 112-bit command frame serially, then performs one access on the selected OpenRAM macro when the tester strobes global_csb.
- Captures read data and loads it into the frame's din fields so the tester can shift it back out on scan_out.
- Sits between the GPIO pads and the SRAM macro array.

Parameters:
- NUM_SRAMS, 16, number of attached macros; sel values >= NUM_SRAMS address nothing.
- DUAL_PORT_MASK, 16'h00FF, bit i set = macro i has a second (read/write) port.
- ADDR_WIDTH, 16, address field width.
- DATA_WIDTH, 32, data field width.
- WMASK_WIDTH, 4, write-mask field width.

Ports:
- clk  in  1  scan/access clock (GPIO clock).
- reset  in  1  asynchronous, active-high reset.
- scan_en  in  1  shift enable.
- scan_in  in  1  serial frame input.
- scan_out  out  1  serial output = frame register bit 111.
- sram_load  in  1  copy captured read data into frame.
- global_csb  in  1  active-low access strobe.
- busy  out  1  high while an access is in progress.
- sram_csb0  out  NUM_SRAMS  per-macro port-0 chip select, active low.
- sram_web0  out  1  port-0 write enable, active low.
- sram_addr0  out  ADDR_WIDTH  port-0 address.
- sram_din0  out  DATA_WIDTH  port-0 write data.
- sram_wmask0  out  WMASK_WIDTH  port-0 write mask.
- sram_csb1, sram_web1, sram_addr1, sram_din1, sram_wmask1  out  same widths  port-1 equivalents.
- sram_dout0  in  NUM_SRAMS*DATA_WIDTH  concatenated port-0 read data; macro i at slice i.
- sram_dout1  in  NUM_SRAMS*DATA_WIDTH  concatenated port-1 read data.

Behaviour:
- Frame, MSB first: {sel[3:0], addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1} = 112 bits.
- Reset values:
  - Frame register, dout0/dout1 capture registers and all address/data/mask outputs: 0.
  - sram_csb0 and sram_csb1: all ones. sram_web0 and sram_web1: 1.
  - busy: 0. scan_out: 0. FSM: IDLE. Strobe arm flag: set.
- Reset asserted mid-access aborts the access immediately; no partial state survives.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE, one action per edge, priority scan_en > sram_load > strobe:
  - scan_en=1: frame shifts left one bit per edge; scan_in enters bit 0. After 112 shifts the first bit received is bit 111 (sel MSB).
  - sram_load=1 (scan_en=0): din0 field <= dout0 capture reg if captured port 0 was a read (csb0=0, web0=1); otherwise din0 is unchanged. din1 follows the same rule with port-1 fields. All other fields unchanged.
  - Strobe: global_csb sampled 0 while the arm flag is set -> ACCESS; clear arm flag.
  - Arm flag re-sets only when global_csb is sampled 1, so holding global_csb low gives exactly one access.
- ACCESS, exactly one cycle, busy=1:
  - Shared outputs driven from the frame fields.
  - sram_csb0[sel] = csb0 field; all other sram_csb0 bits = 1.
  - sram_csb1[sel] = csb1 field only if DUAL_PORT_MASK[sel]=1; otherwise 1.
  - sel >= NUM_SRAMS: all csb bits stay 1.
  - Next state: CAPTURE.
- CAPTURE, one cycle, busy=1:
  - All csb = 1.
  - At the end of the cycle, capture dout0 slice [sel] and dout1 slice [sel] into the capture regs.
  - Capture 0 for an out-of-range sel, and capture dout1 as 0 for a macro with no second port.
  - Next state: IDLE.
- Access latency: strobe sampled at edge N; csb low during cycle N..N+1; data captured at edge N+2; sram_load honoured from edge N+2 on.
- scan_en, sram_load and global_csb are ignored while busy. The frame register is not modified during an access.
- scan_out is combinational from frame bit 111, so the MSB is valid before the first shift edge.
- Port-0 and port-1 writes to the same address in one access are passed straight to the macro; this block does no arbitration.

Test Plan:
- Shift-through: scan 112 bits of a random frame, then 112 more bits with scan_en=1 -> scan_out returns the first frame bit-exact; no csb ever goes low.
- Write then read, macro 3:
  - Write frame sel=3, addr0=1, din0=0x00000003, csb0=0, web0=0; strobe -> sram_csb0=16'hFFF7 for exactly one cycle with web0=0; busy high for 2 cycles.
  - Read frame (csb0=0, web0=1, addr0=1), strobe, wait 2 cycles, pulse sram_load, shift out -> din0 field = 0x00000003; other fields equal to the shifted-in values.
- Dual-port read on macro 5: port 0 reads addr 1, port 1 reads addr 2 (previously written 0x28) -> after load, din0=5 and din1=0x28.
- Single-port macro 9 with csb1=0 -> sram_csb1 stays 16'hFFFF; the din1 field after load = 0.
- global_csb held low for 10 cycles -> exactly one ACCESS; release and re-strobe -> a second access.
- Reset mid-access: reset asserted in the ACCESS cycle -> csb all ones, busy=0, frame=0 asynchronously; a subsequent shift-through passes.
